tap_bank_interleave: RTL
========================

Name: tap_bank_interleave

Overview:
- Parametrised multi-lane tap-coefficient memory bank for the fully-connected stage datapath; successor to the fixed 6-lane, 32-bit, 16-deep tap store.
- Holds LANES independent DATA_W×DEPTH synchronous RAMs and presents them as one LANES*DATA_W word.
- Supports direct addressing, rotating interleaved read addressing and single-lane sub-word writes.
- Adds registered read-valid, write-first collision handling and a post-reset clear sequencer.

Parameters:
- LANES, 6, number of memory lanes (2..16).
- DATA_W, 32, bits per lane.
- DEPTH, 16, words per lane (power of 2).
- ADDR_W, $clog2(DEPTH), address width (derived).
- LANE_W, $clog2(LANES), sub-lane select width (derived).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- rd_vld  in  1  read request.
- rd_address  in  ADDR_W  direct read address.
- wr_vld  in  1  full-width write request.
- wr_address  in  ADDR_W  write address, shared by full and sub writes.
- wr_data  in  LANES*DATA_W  full-width write data; lane i is bits [i*DATA_W +: DATA_W].
- sub_vld  in  1  single-lane write request.
- sub_addr  in  LANE_W  target lane for the sub write.
- sub_data  in  DATA_W  sub write data.
- inter  in  1  interleave step strobe.
- inter_first  in  1  interleave restart.
- rd_data  out  LANES*DATA_W  read data.
- rd_data_vld  out  1  rd_data valid.
- busy  out  1  clear sequencer active.

Behaviour:
- Reset (reset=0): rd_data=0, rd_data_vld=0, busy=0, cnt0=0, cnt1=0. Asynchronous assert, synchronous release.
- Reads: rd_vld in cycle N gives rd_data/rd_data_vld in cycle N+1 (latency 1). rd_data holds its value when rd_vld=0. rd_data_vld is a 1-cycle pulse per request.
- Interleave counters:
  - cnt0 (LANE_W+1 bits) and cnt1 (ADDR_W bits) update only when inter=1 or inter_first=1.
  - inter_first=1 forces cnt0=0 and cnt1=0. This has priority over inter.
  - inter=1 with cnt0==LANES-1: cnt0←0, cnt1←(cnt1+LANES) mod DEPTH.
  - inter=1 otherwise: cnt0←cnt0+1.
  - cnt1 advances only on an inter step, never on a bare cnt0==LANES-1.
- Lane i read address:
  - If inter & ~inter_first: ((cnt0+i) mod LANES + cnt1) mod DEPTH.
  - Otherwise: rd_address.
  - The modulo is a single conditional subtract of LANES; the final sum truncates to ADDR_W (wraps).
- Writes:
  - Lane i writes when (sub_vld & sub_addr==i), or when (wr_vld & ~sub_vld).
  - Sub write data is sub_data; full write data is lane i of wr_data.
  - sub_vld suppresses full writes on all lanes.
  - sub_addr ≥ LANES writes nothing.
- Collision: a read and write to the same lane and address in the same cycle is write-first; next-cycle rd_data carries the new data.
- While busy=1: external rd_vld, wr_vld and sub_vld are ignored; rd_data_vld stays 0; counters still update.

Optional Feature:
- Macro TAP_BANK_CLEAR_EN.
- Defined:
  - 2-state FSM IDLE/CLEAR. Reset puts the FSM in CLEAR, clear address 0, busy=1.
  - Each cycle writes 0 to all lanes at the clear address, then increments it.
  - After address DEPTH-1 is written, moves to IDLE and busy←0, so busy is high for exactly DEPTH cycles after reset release.
  - Reset asserted mid-clear restarts at address 0.
- Not defined: no FSM, busy tied 0, memory contents uninitialised (simulation may preload by $readmemh per lane instance).

Decomposition:
- Package tap_bank_pkg: interleave counter width function and the clear FSM state enum.
- Sub-module tap_bank_lane: one DATA_W×DEPTH RAM with registered read and write-first bypass, instantiated LANES times by a generate loop.

Test Plan (LANES=6, DATA_W=32, DEPTH=16):
1. Full write addr 3, lane i data 0x100+i; read addr 3 → next cycle rd_data lane i = 0x100+i, rd_data_vld=1 for exactly 1 cycle.
2. Interleave offset: after inter_first, 3 inter strobes (cnt0=3) with inter=1 → lane 4 reads addr 1, lane 0 reads addr 3.
3. Interleave wrap: inter_first then 6 inter strobes → cnt0=0, cnt1=6, lane 0 reads addr 6. 16 further strobes wrap cnt1 to (6+12) mod 16=2.
4. Sub write plus full write: sub_vld lane 2 data 0xDEAD with wr_vld addr 5 in the same cycle → only lane 2 addr 5 changes; other lanes keep old values.
5. Collision: write 0xBEEF and read of the same lane/addr in one cycle → next-cycle rd_data = 0xBEEF.
6. With TAP_BANK_CLEAR_EN: release reset → busy high 16 cycles, a write issued in cycle 4 is ignored, all addresses read 0. Reasserting reset at cycle 8 restarts the 16-cycle count.

Source files
------------

// File: rtl/tap_bank_pkg.sv
// -----------------------------------------------------------------------------
// tap_bank_pkg
// Shared definitions for the tap-coefficient memory bank.
//   - cnt0_width(): width of the interleave lane-offset counter. One bit wider
//     than the lane-select field so the counter can represent LANES itself
//     when LANES is a power of two.
//   - clr_state_t : state encoding of the post-reset clear sequencer. That
//     sequencer is only built when TAP_BANK_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
package tap_bank_pkg;

    // Width of the interleave lane-offset counter for a given lane count.
    function automatic int cnt0_width(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

    // Clear sequencer states.
    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/tap_bank_lane.sv
// -----------------------------------------------------------------------------
// tap_bank_lane
// One DATA_W x DEPTH synchronous RAM lane with a registered read port.
// A read and a write to the same address in the same cycle are write-first:
// the read register captures the incoming write data, not the old contents.
// The read register holds its value while rd_en is low.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (clears the read register only)
//   rd_en    in   read enable
//   rd_addr  in   read address
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_q     out  registered read data
// -----------------------------------------------------------------------------
module tap_bank_lane
    import tap_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_q
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_q_r;
    logic              bypass_s;

    // Write-first bypass select: the read and the write hit the same word.
    always_comb begin
        bypass_s = 1'b0;
        if (wr_en && (wr_addr == rd_addr)) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
    end

    // Storage array. It has no reset so that it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port. It takes the new data when a write hits the same word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            if (bypass_s) begin
                rd_q_r <= wr_data;
            end else begin
                rd_q_r <= mem_r[rd_addr];
            end
        end
    end

    assign rd_q = rd_q_r;

endmodule

// File: rtl/tap_bank_interleave.sv
// -----------------------------------------------------------------------------
// tap_bank_interleave
// Multi-lane tap-coefficient memory bank. It holds LANES independent
// DATA_W x DEPTH RAMs and presents them as one LANES*DATA_W word.
//
// Addressing modes:
//   - Direct read     : every lane reads rd_address.
//   - Interleaved read: (inter & ~inter_first) makes lane i read
//                       ((cnt0 + i) mod LANES + cnt1) mod DEPTH.
//   - Full write      : every lane writes its slice of wr_data at wr_address.
//   - Sub write       : the single lane sub_addr writes sub_data. sub_vld
//                       suppresses the full write on all lanes.
// Read latency is one cycle. rd_data holds its value between reads, and
// rd_data_vld pulses once per accepted read.
//
// Optional feature (macro TAP_BANK_CLEAR_EN): after reset release, a clear
// sequencer zeroes every address of every lane over DEPTH cycles. busy is
// high during that time and external accesses are ignored. Without the
// macro, busy is tied low and the RAM contents start uninitialised.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   rd_vld       in   read request
//   rd_address   in   direct read address
//   wr_vld       in   full-width write request
//   wr_address   in   write address (full and sub writes)
//   wr_data      in   full-width write data, lane i = [i*DATA_W +: DATA_W]
//   sub_vld      in   single-lane write request
//   sub_addr     in   target lane of the sub write
//   sub_data     in   sub write data
//   inter        in   interleave step strobe
//   inter_first  in   interleave restart (takes priority over inter)
//   rd_data      out  read data
//   rd_data_vld  out  read data valid pulse
//   busy         out  clear sequencer active
// -----------------------------------------------------------------------------
module tap_bank_interleave
    import tap_bank_pkg::*;
#(
    parameter int LANES  = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_vld,
    input  logic [ADDR_W-1:0]       rd_address,
    input  logic                    wr_vld,
    input  logic [ADDR_W-1:0]       wr_address,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic                    sub_vld,
    input  logic [LANE_W-1:0]       sub_addr,
    input  logic [DATA_W-1:0]       sub_data,
    input  logic                    inter,
    input  logic                    inter_first,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_data_vld,
    output logic                    busy
);

    localparam int CNT0_W = cnt0_width(LANES);

    logic [CNT0_W-1:0] cnt0_r;
    logic [ADDR_W-1:0] cnt1_r;
    logic              rd_data_vld_r;
    logic              busy_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              rd_en_s;
    logic              inter_rd_s;

`ifdef TAP_BANK_CLEAR_EN
    clr_state_t        clr_state_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic              busy_r;

    // Clear sequencer: reset loads CLEAR. It then walks every address once and settles in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_state_r <= CLR_CLEAR;
            clr_addr_r  <= {ADDR_W{1'b0}};
            busy_r      <= 1'b1;
        end else begin
            case (clr_state_r)
                CLR_CLEAR: begin
                    if (clr_addr_r == ADDR_W'(DEPTH - 1)) begin
                        clr_state_r <= CLR_IDLE;
                        clr_addr_r  <= {ADDR_W{1'b0}};
                        busy_r      <= 1'b0;
                    end else begin
                        clr_addr_r  <= clr_addr_r + ADDR_W'(1);
                        busy_r      <= 1'b1;
                    end
                end
                CLR_IDLE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    clr_state_r <= CLR_IDLE;
                    clr_addr_r  <= {ADDR_W{1'b0}};
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we_s   = (clr_state_r == CLR_CLEAR);
    assign clr_addr_s = clr_addr_r;
    assign busy_s     = busy_r;
`else
    assign clr_we_s   = 1'b0;
    assign clr_addr_s = {ADDR_W{1'b0}};
    assign busy_s     = 1'b0;
`endif

    // Request qualification: external reads are blocked while clearing.
    always_comb begin
        rd_en_s    = rd_vld & ~busy_s;
        inter_rd_s = inter & ~inter_first;
    end

    // Interleave counters. They keep stepping while busy, and cnt1 moves only on an inter wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_r <= CNT0_W'(0);
            cnt1_r <= ADDR_W'(0);
        end else if (inter_first) begin
            cnt0_r <= CNT0_W'(0);
            cnt1_r <= ADDR_W'(0);
        end else if (inter) begin
            if (cnt0_r == CNT0_W'(LANES - 1)) begin
                cnt0_r <= CNT0_W'(0);
                // Truncation to ADDR_W is the mod DEPTH (DEPTH is a power of two).
                cnt1_r <= cnt1_r + ADDR_W'(LANES);
            end else begin
                cnt0_r <= cnt0_r + CNT0_W'(1);
            end
        end
    end

    // Read-valid pulse, one per accepted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_vld_r <= 1'b0;
        end else begin
            rd_data_vld_r <= rd_en_s;
        end
    end

    assign rd_data_vld = rd_data_vld_r;
    assign busy        = busy_s;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CNT0_W:0]    off_sum_s;
        logic [CNT0_W:0]    off_mod_s;
        logic [ADDR_W-1:0]  lane_raddr_s;
        logic               lane_we_s;
        logic [ADDR_W-1:0]  lane_waddr_s;
        logic [DATA_W-1:0]  lane_wdata_s;

        // Lane read address. (cnt0 + i) is below 2*LANES, so one conditional subtract gives the mod.
        always_comb begin
            off_sum_s = {1'b0, cnt0_r} + (CNT0_W + 1)'(i);
            if (off_sum_s >= (CNT0_W + 1)'(LANES)) begin
                off_mod_s = off_sum_s - (CNT0_W + 1)'(LANES);
            end else begin
                off_mod_s = off_sum_s;
            end
            if (inter_rd_s) begin
                lane_raddr_s = ADDR_W'(off_mod_s) + cnt1_r;
            end else begin
                lane_raddr_s = rd_address;
            end
        end

        // Lane write port: the clear sequencer overrides everything, then sub write, then full write.
        always_comb begin
            lane_we_s    = 1'b0;
            lane_waddr_s = wr_address;
            lane_wdata_s = wr_data[i*DATA_W +: DATA_W];
            if (clr_we_s) begin
                lane_we_s    = 1'b1;
                lane_waddr_s = clr_addr_s;
                lane_wdata_s = {DATA_W{1'b0}};
            end else if (busy_s) begin
                lane_we_s    = 1'b0;
            end else if (sub_vld) begin
                // Out-of-range sub_addr values match no lane.
                lane_we_s    = (sub_addr == LANE_W'(i));
                lane_wdata_s = sub_data;
            end else begin
                lane_we_s    = wr_vld;
            end
        end

        tap_bank_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .rd_en   (rd_en_s),
            .rd_addr (lane_raddr_s),
            .wr_en   (lane_we_s),
            .wr_addr (lane_waddr_s),
            .wr_data (lane_wdata_s),
            .rd_q    (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule
